ds_capture_fifo: RTL
====================

DS_CAPTURE_FIFO -- requirements
Module: ds_capture_fifo

Interface
REQ-001 SHALL have parameter SAMPLE_W, default 16, I/Q sample width in bits.
REQ-002 SHALL have parameter DEPTH_LOG2, default 6, giving FIFO depth 2**DEPTH_LOG2 I/Q pairs (64).
REQ-003 SHALL have port sys_clk  input  1  the single clock for all logic.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_x  input  SAMPLE_W  signed downsampled I sample from downsamplerFilter.
REQ-006 SHALL have port in_y  input  SAMPLE_W  signed downsampled Q sample.
REQ-007 SHALL have port in_ce  input  1  one-cycle strobe; the in_x/in_y pair is valid on this cycle.
REQ-008 SHALL have port rd_en  input  1  CPU pop request.
REQ-009 SHALL have port flush  input  1  synchronous FIFO clear.
REQ-010 SHALL have port clear_overflow  input  1  clears the sticky overflow flag.
REQ-011 SHALL have port out_x  output  SAMPLE_W  head-of-FIFO I sample.
REQ-012 SHALL have port out_y  output  SAMPLE_W  head-of-FIFO Q sample.
REQ-013 SHALL have port out_valid  output  1  FIFO holds at least one pair.
REQ-014 SHALL have port level  output  DEPTH_LOG2+1  number of stored pairs, 0 to 2**DEPTH_LOG2.
REQ-015 SHALL have port overflow  output  1  sticky flag: a sample was dropped.

Function
REQ-016 SHALL store {in_x, in_y} atomically on a sys_clk edge with in_ce=1 when level < DEPTH or a pop occurs on the same edge.
REQ-017 SHALL drop the new pair when in_ce=1, level=DEPTH and no pop occurs, and SHALL leave stored data unchanged.
REQ-018 SHALL set overflow on each drop; set SHALL win over clear_overflow on the same edge.
REQ-019 SHALL treat rd_en=1 with out_valid=1 as a pop that advances the head by one pair. rd_en with out_valid=0 SHALL be ignored.
REQ-020 SHALL present the head pair first-word-fall-through on out_x/out_y, registered, with out_valid=1. Data and valid SHALL appear on the edge after the write.
REQ-021 SHALL present the next pair on the edge after a pop; out_valid SHALL stay 1 across back-to-back pops while data remains.
REQ-022 SHALL hold out_x/out_y stable while out_valid=1 and no pop occurs.
REQ-023 SHALL, for a simultaneous push and pop, keep level unchanged, including at level=DEPTH and level=1.
REQ-024 SHALL, for a push into an empty FIFO with rd_en=1 on the same edge, accept the push and ignore the pop.
REQ-025 SHALL wrap the read and write pointers modulo DEPTH, using an extra MSB to separate full from empty.
REQ-026 SHALL keep level registered and exact after every edge.
REQ-027 SHALL give flush priority over push and pop. Flush SHALL set level=0 and out_valid=0 on the next edge, discard any same-edge in_ce sample, and leave overflow untouched.
REQ-028 SHALL never modify sample values: no rounding, no sign change, no width change.

Reset
REQ-029 SHALL, while rst=1, force pointers=0, level=0, out_valid=0, overflow=0 and out_x=out_y=0, independent of sys_clk.
REQ-030 SHALL, on reset mid-operation, lose all stored pairs. The first in_ce after rst deasserts SHALL be accepted normally.
REQ-031 SHALL NOT reset the storage array itself.

Configuration
REQ-032 SHALL, with macro UBERCLOCK_FIFO_DROP_CNT_EN defined, add output drop_count (16 bits). drop_count SHALL increment on each dropped pair, saturate at 0xFFFF, clear on clear_overflow or rst, and be unaffected by flush.
REQ-033 SHALL, without UBERCLOCK_FIFO_DROP_CNT_EN, omit the drop_count port and its logic; all other behaviour SHALL be identical.

Structure
REQ-034 SHALL take SAMPLE_W default (16) and DEPTH_LOG2 default (6) from shared package uberclock_pkg, alongside the existing datapath width constants.
REQ-035 SHALL place the storage in one sub-module ds_fifo_mem: a simple dual-port array, one write port and one registered read port, inferable as block/distributed RAM.

Verification
REQ-036 Single push: rst, then in_ce with x=0x1234, y=0xFEDC -> next edge out_valid=1, out_x=0x1234, out_y=0xFEDC, level=1.
REQ-037 Fill plus one: push 65 pairs x=0..64 with no reads -> level=64, overflow=1, drop_count=1; popping 64 times yields x=0..63 in order, then out_valid=0.
REQ-038 Full with simultaneous push/pop: at level=64, in_ce with x=0x7FFF together with rd_en -> level stays 64, overflow unchanged, 0x7FFF read out last.
REQ-039 Flush race: level=5, flush, in_ce and rd_en on one edge -> level=0, out_valid=0, overflow unchanged, next push is read back first.
REQ-040 Async reset mid-stream: assert rst between edges at level=10 -> level=0, out_valid=0, overflow=0 immediately; pushes after deassert are read back in order.
REQ-041 Overflow clear race: drop and clear_overflow on the same edge -> overflow=1; clear_overflow alone on a later edge -> overflow=0.

Source files
------------

// File: rtl/uberclock_pkg.sv
// uberclock_pkg -- shared constants for the uberclock receive datapath.
//
// Holds the datapath width constants used across the receive chain, plus the
// defaults for the downsampled capture FIFO (ds_capture_fifo) and a small
// saturating-increment helper for 16-bit event counters.
package uberclock_pkg;

  // Existing datapath widths of the receive chain.
  localparam int ADC_W          = 12;  // raw ADC sample width
  localparam int MIX_W          = 24;  // mixer / NCO product width
  localparam int DS_OUT_W       = 16;  // downsamplerFilter output width

  // Capture FIFO defaults.
  localparam int FIFO_SAMPLE_W   = DS_OUT_W;  // I/Q sample width
  localparam int FIFO_DEPTH_LOG2 = 6;         // 64 I/Q pairs

  // Increment a 16-bit counter, holding at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/ds_fifo_mem.sv
// ds_fifo_mem -- simple dual-port storage for the capture FIFO.
//
// One write port and one registered read port, written so synthesis maps it
// onto block or distributed RAM. The array has no reset.
//
// Ports:
//   sys_clk  in   clock
//   wr_en    in   write strobe
//   wr_addr  in   ADDR_W   write address
//   wr_data  in   DATA_W   write data
//   rd_addr  in   ADDR_W   read address, sampled on sys_clk
//   rd_data  out  DATA_W   registered read data (one cycle after rd_addr)
module ds_fifo_mem #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6
) (
  input  logic              sys_clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];

  always_ff @(posedge sys_clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/ds_capture_fifo.sv
// ds_capture_fifo -- capture FIFO for downsampled I/Q pairs read by the CPU.
//
// Stores {in_x, in_y} pairs strobed by in_ce and presents the head pair
// first-word-fall-through. A push into a full FIFO without a same-edge pop is
// dropped and sets the sticky overflow flag.
//
// Optional feature: define UBERCLOCK_FIFO_DROP_CNT_EN to add the 16-bit
// saturating drop_count output (cleared by clear_overflow or rst, not flush).
//
// Ports:
//   sys_clk         in   clock
//   rst             in   asynchronous active-high reset
//   in_x, in_y      in   SAMPLE_W  signed I/Q sample pair
//   in_ce           in   pair valid strobe
//   rd_en           in   pop request (ignored while empty)
//   flush           in   synchronous clear, highest priority
//   clear_overflow  in   clears overflow (a same-edge drop wins)
//   out_x, out_y    out  SAMPLE_W  head pair
//   out_valid       out  FIFO not empty
//   level           out  DEPTH_LOG2+1  number of stored pairs
//   overflow        out  sticky drop flag
//   drop_count      out  16  (only with UBERCLOCK_FIFO_DROP_CNT_EN)
module ds_capture_fifo
  import uberclock_pkg::*;
#(
  parameter int SAMPLE_W   = FIFO_SAMPLE_W,
  parameter int DEPTH_LOG2 = FIFO_DEPTH_LOG2
) (
  input  logic                  sys_clk,
  input  logic                  rst,
  input  logic [SAMPLE_W-1:0]   in_x,
  input  logic [SAMPLE_W-1:0]   in_y,
  input  logic                  in_ce,
  input  logic                  rd_en,
  input  logic                  flush,
  input  logic                  clear_overflow,
  output logic [SAMPLE_W-1:0]   out_x,
  output logic [SAMPLE_W-1:0]   out_y,
  output logic                  out_valid,
  output logic [DEPTH_LOG2:0]   level,
`ifdef UBERCLOCK_FIFO_DROP_CNT_EN
  output logic [15:0]           drop_count,
`endif
  output logic                  overflow
);

  localparam int                PAIR_W  = 2 * SAMPLE_W;
  localparam logic [DEPTH_LOG2:0] FULL_XOR = {1'b1, {DEPTH_LOG2{1'b0}}};

  // Pointers carry one extra MSB: equal low bits with differing MSB is full.
  logic [DEPTH_LOG2:0] wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
  logic [DEPTH_LOG2:0] level_reg, level_next;
  logic                valid_reg;
  logic                overflow_reg;
  logic                byp_sel_reg, byp_sel_next;
  logic [PAIR_W-1:0]   byp_data_reg;
  logic [PAIR_W-1:0]   rd_data;
  logic [PAIR_W-1:0]   head_pair;
  logic                full, pop, push, drop;

  always_comb begin
    full         = ((wr_ptr_reg ^ rd_ptr_reg) == FULL_XOR);
    pop          = rd_en && valid_reg && !flush;
    push         = in_ce && !flush && (!full || pop);
    drop         = in_ce && !flush && full && !pop;
    level_next   = level_reg + (DEPTH_LOG2+1)'(push) - (DEPTH_LOG2+1)'(pop);
    rd_ptr_next  = flush ? '0 : rd_ptr_reg + (DEPTH_LOG2+1)'(pop);
    // The new head is the pair being written this edge when nothing older
    // survives the pop; the RAM cannot return it yet, so it is bypassed.
    byp_sel_next = push && ((level_reg == '0) || ((level_reg == 1) && pop));
  end

  // The RAM read address looks one edge ahead so its registered output holds
  // the head pair whenever that pair was written on an earlier edge.
  ds_fifo_mem #(
    .DATA_W (PAIR_W),
    .ADDR_W (DEPTH_LOG2)
  ) u_mem (
    .sys_clk (sys_clk),
    .wr_en   (push),
    .wr_addr (wr_ptr_reg[DEPTH_LOG2-1:0]),
    .wr_data ({in_x, in_y}),
    .rd_addr (rd_ptr_next[DEPTH_LOG2-1:0]),
    .rd_data (rd_data)
  );

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
      valid_reg    <= 1'b0;
      byp_sel_reg  <= 1'b1;   // selects the zeroed bypass so out_x/out_y read 0
      byp_data_reg <= '0;
    end else if (flush) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
      valid_reg    <= 1'b0;
      byp_sel_reg  <= 1'b0;
    end else begin
      wr_ptr_reg   <= wr_ptr_reg + (DEPTH_LOG2+1)'(push);
      rd_ptr_reg   <= rd_ptr_next;
      level_reg    <= level_next;
      valid_reg    <= (level_next != '0);
      byp_sel_reg  <= byp_sel_next;
      if (byp_sel_next) begin
        byp_data_reg <= {in_x, in_y};
      end
    end
  end

  // Set wins over clear; flush leaves the flag alone.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      overflow_reg <= 1'b0;
    end else if (drop) begin
      overflow_reg <= 1'b1;
    end else if (clear_overflow) begin
      overflow_reg <= 1'b0;
    end
  end

`ifdef UBERCLOCK_FIFO_DROP_CNT_EN
  logic [15:0] drop_cnt_reg;

  // A drop on the clearing edge is counted as the first of the new run.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      drop_cnt_reg <= '0;
    end else if (clear_overflow) begin
      drop_cnt_reg <= drop ? 16'd1 : 16'd0;
    end else if (drop) begin
      drop_cnt_reg <= sat_inc16(drop_cnt_reg);
    end
  end

  assign drop_count = drop_cnt_reg;
`endif

  // Both mux inputs are flops and the select is a flop, so the head is a
  // registered value with no path from any input.
  assign head_pair = byp_sel_reg ? byp_data_reg : rd_data;
  assign out_x     = head_pair[PAIR_W-1:SAMPLE_W];
  assign out_y     = head_pair[SAMPLE_W-1:0];
  assign out_valid = valid_reg;
  assign level     = level_reg;
  assign overflow  = overflow_reg;

endmodule
